// File: rtl/clk_wiz_ila.sv
// rtl/clk_wiz_ila.sv - divide-by-4 quadrature clock generator with lock delay plus a triggered 11-bit logic analyser
`timescale 1ns/1ps
module clk_wiz_ila #(
  parameter int DEPTH       = 64,
  parameter int LOCK_CYCLES = 8,
  localparam int AW         = $clog2(DEPTH),
  localparam int LW         = $clog2(LOCK_CYCLES + 1)
) (
  input  logic          clk_in1,
  input  logic          resetn,
  output logic          clk_out1,
  output logic          clk_out2,
  output logic          clk_out3,
  output logic          clk_out4,
  output logic          locked,
  input  logic [4:0]    probe0,
  input  logic          probe1,
  input  logic          probe2,
  input  logic          probe3,
  input  logic          probe4,
  input  logic          probe5,
  input  logic          probe6,
  input  logic          arm,
  input  logic [10:0]   trig_mask,
  input  logic [10:0]   trig_value,
  input  logic [AW-1:0] rd_addr,
  output logic [10:0]   rd_data,
  output logic          armed,
  output logic          triggered,
  output logic          done
);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

  state_t        state, state_nxt;
  logic [10:0]   sample;
  logic [1:0]    cnt, cnt_nxt;
  logic [LW-1:0] lock_cnt;
  logic          locked_nxt;
  logic          hit;
  logic          wr_en;
  logic [AW-1:0] wr_addr, wr_ptr;
  logic [10:0]   mem [DEPTH];

  assign sample     = {probe6, probe5, probe4, probe3, probe2, probe1, probe0};
  assign hit        = ((sample ^ trig_value) & trig_mask) == 11'd0;
  assign cnt_nxt    = cnt + 2'd1;
  assign locked_nxt = locked | (lock_cnt == LW'(LOCK_CYCLES - 1));

  // Phase outputs decode the next count so each register matches cnt in the same cycle.
  always_ff @(posedge clk_in1 or negedge resetn) begin
    if (!resetn) begin
      cnt      <= 2'd0;
      lock_cnt <= '0;
      locked   <= 1'b0;
      clk_out1 <= 1'b0;
      clk_out2 <= 1'b0;
      clk_out3 <= 1'b0;
      clk_out4 <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      if (!locked) lock_cnt <= lock_cnt + LW'(1);
      locked   <= locked_nxt;
      clk_out1 <= locked_nxt & (cnt_nxt == 2'd0 || cnt_nxt == 2'd1);
      clk_out2 <= locked_nxt & (cnt_nxt == 2'd1 || cnt_nxt == 2'd2);
      clk_out3 <= locked_nxt & (cnt_nxt == 2'd2 || cnt_nxt == 2'd3);
      clk_out4 <= locked_nxt & (cnt_nxt == 2'd3 || cnt_nxt == 2'd0);
    end
  end

  always_ff @(posedge clk_in1 or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    wr_ptr    = wr_addr;
    case (state)
      IDLE, DONE: if (arm) state_nxt = ARMED;
      ARMED: begin
        if (hit) begin
          wr_en     = 1'b1;
          wr_ptr    = '0;
          state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        wr_en = 1'b1;
        if (wr_addr == AW'(DEPTH - 1)) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in1 or negedge resetn) begin
    if (!resetn)    wr_addr <= '0;
    else if (wr_en) wr_addr <= wr_ptr + AW'(1);
  end

  // Buffer has no reset so an aborted capture keeps what it already stored.
  always_ff @(posedge clk_in1) begin
    if (wr_en) mem[wr_ptr] <= sample;
  end

  always_ff @(posedge clk_in1 or negedge resetn) begin
    if (!resetn) rd_data <= 11'd0;
    else         rd_data <= mem[rd_addr];
  end

  assign armed     = (state == ARMED);
  assign triggered = (state == CAPTURE) || (state == DONE);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_clk_wiz_ila.sv
// tb/tb_clk_wiz_ila.sv - scoreboard bench for clk_wiz_ila: lock/phase sequence, triggered captures, abort by reset
`timescale 1ns/1ps
module tb_clk_wiz_ila;
  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int LOCK  = 8;

  logic          clk_in1 = 1'b0;
  logic          resetn  = 1'b0;
  logic          clk_out1, clk_out2, clk_out3, clk_out4, locked;
  logic [4:0]    probe0;
  logic          probe1, probe2, probe3, probe4, probe5, probe6;
  logic          arm = 1'b0;
  logic [10:0]   trig_mask = 11'd0, trig_value = 11'd0;
  logic [AW-1:0] rd_addr = '0;
  logic [10:0]   rd_data;
  logic          armed, triggered, done;

  logic [10:0]   s_drv = 11'd0;
  logic [3:0]    clk_outs;
  logic [10:0]   exp_buf [DEPTH];
  logic [10:0]   rd_q [$];
  int            rd_qa [$];
  logic          rd_req = 1'b0, rd_req_q = 1'b0;
  int            n_checks = 0, n_pass = 0;

  assign {probe6, probe5, probe4, probe3, probe2, probe1, probe0} = s_drv;
  assign clk_outs = {clk_out4, clk_out3, clk_out2, clk_out1};

  clk_wiz_ila #(.DEPTH(DEPTH), .LOCK_CYCLES(LOCK)) dut (
    .clk_in1(clk_in1), .resetn(resetn),
    .clk_out1(clk_out1), .clk_out2(clk_out2), .clk_out3(clk_out3), .clk_out4(clk_out4),
    .locked(locked),
    .probe0(probe0), .probe1(probe1), .probe2(probe2), .probe3(probe3),
    .probe4(probe4), .probe5(probe5), .probe6(probe6),
    .arm(arm), .trig_mask(trig_mask), .trig_value(trig_value),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .armed(armed), .triggered(triggered), .done(done)
  );

  always #5 clk_in1 = ~clk_in1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk_in1);
    @(negedge clk_in1);
  endtask

  // Read monitor: a request issued before an edge is answered after it.
  always @(posedge clk_in1) rd_req_q <= rd_req;
  always @(negedge clk_in1) begin
    if (rd_req_q) begin
      if (rd_q.size() == 0) check("rd_queue_underflow", 32'd1, 32'd0);
      else begin
        logic [10:0] e;
        int a;
        e = rd_q.pop_front();
        a = rd_qa.pop_front();
        check($sformatf("rd_data[%0d]", a), {21'd0, rd_data}, {21'd0, e});
      end
    end
  end

  function automatic logic [10:0] pat(input int mode, input int i);
    case (mode)
      0:       return {6'($urandom), 5'(i)};
      1:       return {6'($urandom), 5'(i - 1)};
      2:       return 11'($urandom);
      default: return (i >= 5) ? 11'h400 : 11'h000;
    endcase
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, "_locked"}, locked, 1'b0);
    check({tag, "_clk_outs"}, clk_outs, 4'd0);
    check({tag, "_armed"}, armed, 1'b0);
    check({tag, "_triggered"}, triggered, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_rd_data"}, rd_data, 11'd0);
  endtask

  // Model: trigger on first evaluated ARMED cycle whose sample matches, then store DEPTH consecutive samples.
  task automatic run_capture(input int mode, input logic [10:0] mask, input logic [10:0] value,
                             input int arm_at, input int abort_at, input bit was_done);
    int trig_i, stored;
    logic [10:0] s;
    bit fin;
    trig_i = -1;
    stored = 0;
    fin    = 1'b0;
    check("pre_arm_done", done, was_done);
    trig_mask  = mask;
    trig_value = value;
    arm        = 1'b1;
    s_drv      = pat(mode, 0);
    step();
    arm = 1'b0;
    check("arm_armed", armed, 1'b1);
    check("arm_done", done, 1'b0);
    check("arm_triggered", triggered, 1'b0);
    for (int i = 1; i <= 400 && !fin; i++) begin
      if (abort_at >= 0 && stored == abort_at) begin
        resetn = 1'b0;
        #1;
        check_reset_state("abort");
        fin = 1'b1;
      end else begin
        s     = pat(mode, i);
        s_drv = s;
        arm   = (arm_at >= 0 && stored == arm_at);
        step();
        arm = 1'b0;
        if (trig_i < 0 && ((s ^ value) & mask) == 11'd0) trig_i = i;
        if (trig_i >= 0 && stored < DEPTH) begin
          exp_buf[stored] = s;
          stored++;
        end
        check($sformatf("armed@%0d", i), armed, trig_i < 0);
        check($sformatf("triggered@%0d", i), triggered, trig_i >= 0);
        check($sformatf("done@%0d", i), done, stored == DEPTH);
        if (stored == DEPTH) fin = 1'b1;
      end
    end
    if (!fin) check("capture_timeout", 32'd0, 32'd1);
  endtask

  task automatic read_all();
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr = AW'(a);
      rd_req  = 1'b1;
      rd_q.push_back(exp_buf[a]);
      rd_qa.push_back(a);
      step();
    end
    rd_req = 1'b0;
    step();
    check("rd_queue_drained", rd_q.size(), 32'd0);
  endtask

  task automatic read_one(input int a, output logic [10:0] d);
    rd_addr = AW'(a);
    step();
    d = rd_data;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    logic [10:0] d;
    @(negedge clk_in1);
    step();
    check_reset_state("reset");
    resetn = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      step();
      check($sformatf("locked@%0d", e), locked, e >= LOCK);
      for (int k = 0; k < 4; k++)
        check($sformatf("clk_out%0d@%0d", k + 1, e), clk_outs[k],
              (e >= LOCK) && (((e - k + 8) % 4) < 2));
    end

    run_capture(0, 11'h000, 11'h000, -1, -1, 1'b0);
    read_all();

    run_capture(1, 11'h01F, 11'h011, 10, -1, 1'b1);
    read_all();
    read_one(0, d);
    check("ramp_addr0_probe0", d[4:0], 5'd17);

    run_capture(3, 11'h400, 11'h400, -1, -1, 1'b1);
    read_one(0, d);
    check("probe6_addr0", d, 11'h400);
    read_all();

    run_capture(2, 11'($urandom) & 11'h00F, 11'($urandom), -1, -1, 1'b1);
    read_all();

    run_capture(2, 11'h000, 11'h000, -1, 30, 1'b1);
    @(negedge clk_in1);
    resetn = 1'b1;
    repeat (10) step();
    read_all();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
